display_mux_scheduler: RTL and testbench

- Time-multiplexing controller that shares one seven-segment decoder and segment bus between NUM_DIGITS common-anode digits.
- Cycles a one-hot, active-low digit enable across the digits.
- Inserts a blanking dead-time before each digit switch so the previous digit does not ghost.
- Takes new digit values through a valid/ready handshake and applies them only at a frame boundary, so a frame never shows a mix of old and new digits.
- Sits between the switch/adder logic and the shared decoder that drives seg.

---
 rtl/display_mux_scheduler_if.sv | 21 ++
 rtl/display_mux_scheduler.sv | 142 ++++++++++++++
 tb/tb_display_mux_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_mux_scheduler_if.sv
// Update channel into the display multiplexer: a valid/ready handshake
// carrying one nibble per digit (digit i lives in bits [4i+3:4i]).
interface display_mux_scheduler_if #(
    parameter int NUM_DIGITS = 2
);
    logic [4*NUM_DIGITS-1:0] upd_data;
    logic                    upd_valid;
    logic                    upd_ready;

    modport master (
        output upd_data,
        output upd_valid,
        input  upd_ready
    );

    modport slave (
        input  upd_data,
        input  upd_valid,
        output upd_ready
    );
endinterface

// File: rtl/display_mux_scheduler.sv
// Time-multiplexing scheduler for NUM_DIGITS common-anode seven-segment
// digits sharing one decoder. Each digit slot is BLANK_CYCLES dark followed
// by ON_CYCLES lit; new digit values are taken over a valid/ready channel and
// only applied at a frame boundary so a frame never mixes old and new data.
// Optional build macro: DISPLAY_MUX_ZERO_BLANK_EN enables leading-zero
// suppression (digit i>0 stays dark when it and every higher digit are 0).
module display_mux_scheduler #(
    parameter int NUM_DIGITS   = 2,
    parameter int BLANK_CYCLES = 2,
    parameter int ON_CYCLES    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    display_mux_scheduler_if.slave  upd,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              hex_sel,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MAX_CYC = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);

    typedef enum logic {
        ST_BLANK,
        ST_ON
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_next;
    logic                    idx_wrap;
    logic [CNT_W-1:0]        cnt;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend;
    logic                    ready_q;
    logic [NUM_DIGITS-1:0]   suppress;
    logic [NUM_DIGITS-1:0]   slot_mask;

    function automatic logic [3:0] nibble_of(input logic [4*NUM_DIGITS-1:0] v, input int i);
        return v[4*i +: 4];
    endfunction

    assign upd.upd_ready = ready_q;
    assign idx_wrap      = (idx == IDX_LAST);
    assign idx_next      = idx_wrap ? '0 : idx + 1'b1;

`ifdef DISPLAY_MUX_ZERO_BLANK_EN
    logic higher_zero;

    // A digit above 0 is suppressed when it and every more significant digit are zero.
    always_comb begin
        suppress    = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            higher_zero = higher_zero && (active[4*i +: 4] == 4'd0);
            suppress[i] = higher_zero;
        end
    end
`else
    assign suppress = '0;
`endif

    // Anode pattern for the current slot while lit: only the selected digit, if enabled.
    always_comb begin
        slot_mask = '1;
        if (digit_en[idx] && !suppress[idx]) begin
            slot_mask[idx] = 1'b0;
        end
    end

    // Slot sequencer, update handshake and frame-boundary apply, all registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_BLANK;
            idx         <= '0;
            cnt         <= '0;
            active      <= '0;
            pending     <= '0;
            pend        <= 1'b0;
            ready_q     <= 1'b1;
            an_n        <= '1;
            hex_sel     <= 4'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;

            if (upd.upd_valid && ready_q) begin
                pending <= upd.upd_data;
                pend    <= 1'b1;
                ready_q <= 1'b0;
            end

            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= ST_ON;
                        cnt   <= '0;
                        an_n  <= slot_mask;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        an_n <= '1;
                    end
                end

                ST_ON: begin
                    if (cnt == ON_LAST) begin
                        state <= ST_BLANK;
                        cnt   <= '0;
                        idx   <= idx_next;
                        an_n  <= '1;
                        if (idx_wrap) begin
                            frame_start <= 1'b1;
                        end
                        if (idx_wrap && pend) begin
                            active  <= pending;
                            pend    <= 1'b0;
                            ready_q <= 1'b1;
                            hex_sel <= nibble_of(pending, 0);
                        end else begin
                            hex_sel <= nibble_of(active, int'(idx_next));
                        end
                    end else begin
                        cnt  <= cnt + 1'b1;
                        an_n <= slot_mask;
                    end
                end

                default: begin
                    state <= ST_BLANK;
                    cnt   <= '0;
                    an_n  <= '1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_display_mux_scheduler.sv
// Scoreboard bench for display_mux_scheduler. The reference model works from
// elapsed cycles since reset: slot = (t / slot_period) % digits, phase =
// t % slot_period, and frame values change only at multiples of the frame
// period. Expected outputs are queued per clock and checked by a monitor.
module tb_display_mux_scheduler;
    localparam int ND = 2;
    localparam int BC = 2;
    localparam int OC = 4;
    localparam int P  = BC + OC;
    localparam int F  = ND * P;

    logic          clk = 1'b0;
    logic          reset;
    logic [ND-1:0] digit_en;
    logic [3:0]    hex_sel;
    logic [ND-1:0] an_n;
    logic          frame_start;

    display_mux_scheduler_if #(.NUM_DIGITS(ND)) upd_bus ();

    display_mux_scheduler #(
        .NUM_DIGITS  (ND),
        .BLANK_CYCLES(BC),
        .ON_CYCLES   (OC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .upd        (upd_bus),
        .digit_en   (digit_en),
        .hex_sel    (hex_sel),
        .an_n       (an_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ND-1:0] an_n;
        logic [3:0]    hex;
        logic          fs;
        logic          rdy;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   armed      = 1'b0;

    // Reference model state: cycle index since reset and the frame contents.
    int            t_now;
    logic [4*ND-1:0] shown;
    bit            has_pend;
    logic [4*ND-1:0] pend_val;
    int            pend_cycle;

    function automatic bit zero_suppressed(input int slot, input logic [4*ND-1:0] v);
        bit all_zero;
        all_zero = 1'b1;
        for (int j = slot; j < ND; j++) begin
            if (v[4*j +: 4] != 4'd0) all_zero = 1'b0;
        end
`ifdef DISPLAY_MUX_ZERO_BLANK_EN
        return (slot > 0) && all_zero;
`else
        return 1'b0 && all_zero;
`endif
    endfunction

    // Advance the model by one clock edge with the given sampled inputs.
    task automatic modelStep(input bit valid, input logic [4*ND-1:0] data, input logic [ND-1:0] en);
        exp_t e;
        int   c;
        int   phase;
        int   slot;
        bit   accept;
        c      = t_now + 1;
        accept = valid && !has_pend;
        if ((c % F == 0) && has_pend && (pend_cycle < c)) begin
            shown    = pend_val;
            has_pend = 1'b0;
        end
        if (accept) begin
            has_pend   = 1'b1;
            pend_val   = data;
            pend_cycle = c;
        end
        phase  = c % P;
        slot   = (c / P) % ND;
        e.an_n = '1;
        if (phase >= BC && en[slot] && !zero_suppressed(slot, shown)) e.an_n[slot] = 1'b0;
        e.hex  = shown[4*slot +: 4];
        e.fs   = (c % F == 0);
        e.rdy  = !has_pend;
        exp_q.push_back(e);
        t_now = c;
    endtask

    task automatic applyStimulus(input bit valid, input logic [4*ND-1:0] data, input logic [ND-1:0] en);
        @(negedge clk);
        reset             = 1'b1;
        upd_bus.upd_valid = valid;
        upd_bus.upd_data  = data;
        digit_en          = en;
        modelStep(valid, data, en);
        armed = 1'b1;
    endtask

    task automatic applyReset();
        exp_t e;
        @(negedge clk);
        reset             = 1'b0;
        upd_bus.upd_valid = 1'b0;
        e.an_n = '1;
        e.hex  = 4'd0;
        e.fs   = 1'b0;
        e.rdy  = 1'b1;
        exp_q.push_back(e);
        t_now    = 0;
        shown    = '0;
        has_pend = 1'b0;
        pend_val = '0;
        armed    = 1'b1;
    endtask

    task automatic idle(input int cycles, input logic [ND-1:0] en);
        for (int k = 0; k < cycles; k++) applyStimulus(1'b0, '0, en);
    endtask

    task automatic timeoutFail(input string what);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired at model cycle %0d", what, t_now);
    endtask

    task automatic checkOutput(input exp_t e);
        exp_t got;
        got = {an_n, hex_sel, frame_start, upd_bus.upd_ready};
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("[TB] FAIL cycle_outputs @%0t: got an_n=%b hex_sel=%h frame_start=%b upd_ready=%b, expected an_n=%b hex_sel=%h frame_start=%b upd_ready=%b",
                     $time, got.an_n, got.hex, got.fs, got.rdy, e.an_n, e.hex, e.fs, e.rdy);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation after every edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL queue_underflow @%0t: no expectation queued", $time);
                end else begin
                    checkOutput(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [31:0]     rnd;
        logic [4*ND-1:0] rdata;
        bit              found;

        reset             = 1'b0;
        upd_bus.upd_valid = 1'b0;
        upd_bus.upd_data  = '0;
        digit_en          = '1;
        t_now             = 0;
        shown             = '0;
        has_pend          = 1'b0;
        pend_val          = '0;
        pend_cycle        = 0;

        $display("[TB] reset and free-running frames");
        applyReset();
        applyReset();
        idle(2 * F, 2'b11);

        $display("[TB] update 5A mid-frame, ignored 33 while busy");
        idle(3, 2'b11);
        applyStimulus(1'b1, 8'h5A, 2'b11);
        applyStimulus(1'b1, 8'h33, 2'b11);
        idle(2 * F, 2'b11);

        $display("[TB] resend 33 once ready");
        found = 1'b0;
        for (int k = 0; k < 3 * F; k++) begin
            if (!has_pend) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b0, '0, 2'b11);
        end
        if (!found) timeoutFail("ready_for_33");
        applyStimulus(1'b1, 8'h33, 2'b11);
        idle(2 * F, 2'b11);

        $display("[TB] transfer 77 on the frame boundary edge");
        found = 1'b0;
        for (int k = 0; k < 3 * F; k++) begin
            if (((t_now + 1) % F == 0) && !has_pend) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b0, '0, 2'b11);
        end
        if (!found) timeoutFail("boundary_align");
        applyStimulus(1'b1, 8'h77, 2'b11);
        idle(3 * F, 2'b11);

        $display("[TB] digit 1 disabled");
        idle(2 * F, 2'b01);

        $display("[TB] reset during ON window drops pending value");
        found = 1'b0;
        for (int k = 0; k < 3 * F; k++) begin
            if (((t_now + 1) % F == 1) && !has_pend) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b0, '0, 2'b11);
        end
        if (!found) timeoutFail("reset_align");
        applyStimulus(1'b1, 8'h99, 2'b11);
        while ((t_now % P) < BC) applyStimulus(1'b0, '0, 2'b11);
        applyReset();
        idle(3 * F, 2'b11);

        $display("[TB] leading-zero values 07 and 00");
        applyStimulus(1'b1, 8'h07, 2'b11);
        idle(3 * F, 2'b11);
        applyStimulus(1'b1, 8'h00, 2'b11);
        idle(3 * F, 2'b11);
        applyStimulus(1'b1, 8'h10, 2'b11);
        idle(3 * F, 2'b11);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                applyReset();
            end else begin
                rnd   = $urandom;
                rdata = rnd[4*ND-1:0];
                rnd   = $urandom;
                applyStimulus(($urandom_range(0, 3) == 0), rdata, rnd[ND-1:0]);
            end
        end

        @(posedge clk);
        #2;
        armed = 1'b0;
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL queue_leftover: %0d expectations unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
